// File: rtl/i2s_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_rx_pkg
//   Shared constants and types for the I2S capture path. The values match the
//   ones used by audio_drive so that the transmitter and receiver agree on the
//   frame layout.
//   No ports. It provides:
//     AUDIO_DATA_W     bits per channel word
//     I2S_SLOT_W       BCK periods per channel slot
//     I2S_SYNC_STAGES  default synchroniser depth
//     ch_e             word-select channel encoding (0 = left, 1 = right)
// ---------------------------------------------------------------------------
package i2s_rx_pkg;

  localparam int AUDIO_DATA_W    = 16;
  localparam int I2S_SLOT_W      = 16;
  localparam int I2S_SYNC_STAGES = 2;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  localparam ch_e I2S_WS_LEFT = CH_LEFT;

endpackage

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge
//   Brings one asynchronous I2S line into the clk domain through a
//   SYNC_STAGES flip-flop chain and flags its rising edge.
//   Both outputs come from registers, so q and rise have the same delay
//   relative to the pin. This keeps WS/DIN aligned with the BCK strobe.
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous reset, active-high
//     d     in   asynchronous input line
//     q     out  synchronised level
//     rise  out  1-clk strobe on a 0->1 transition of q
// ---------------------------------------------------------------------------
module i2s_sync_edge
  import i2s_rx_pkg::*;
#(
  parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      q     <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~q;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//   Philips-I2S receiver. BCK, WS and DIN are oversampled in the clk domain.
//   Left and right words are deserialised MSB first, and each stereo frame is
//   presented on a valid/ready port. There is a single output register and
//   no FIFO.
//   Ports:
//     clk        in   system clock (>= 8x BCK)
//     rst        in   asynchronous reset, active-high
//     i2s_bck    in   bit clock (asynchronous)
//     i2s_ws     in   word select, 0 = left, 1 = right
//     i2s_din    in   serial data
//     out_l      out  left word of the presented frame
//     out_r      out  right word of the presented frame
//     out_valid  out  frame held on out_l/out_r
//     out_ready  in   consumer accepts when out_valid && out_ready
//     overrun    out  1-clk pulse: completed frame dropped, output full
//     slot_err   out  1-clk pulse: slot closed with wrong bit count
// ---------------------------------------------------------------------------
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int SLOT_W      = I2S_SLOT_W,
  parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i2s_bck,
  input  logic                     i2s_ws,
  input  logic                     i2s_din,
  output logic signed [DATA_W-1:0] out_l,
  output logic signed [DATA_W-1:0] out_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic                     slot_err
);

  localparam int                CNT_W    = $clog2(SLOT_W) + 1;
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(SLOT_W + 1);

  // Slot bit counter: it stops at SLOT_W+1. An over-long slot still reads as
  // wrong, and the counter cannot wrap back to a legal value.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= SAT_CNT) ? SAT_CNT : c + CNT_W'(1);
  endfunction

  // ---- stage p0: synchronised I2S lines and BCK rising strobe ----
  logic bck_rise_p0;
  logic ws_s_p0;
  logic din_s_p0;
  logic bck_s_unused;
  logic ws_rise_unused;
  logic din_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
    .clk  (clk),
    .rst  (rst),
    .d    (i2s_bck),
    .q    (bck_s_unused),
    .rise (bck_rise_p0)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
    .clk  (clk),
    .rst  (rst),
    .d    (i2s_ws),
    .q    (ws_s_p0),
    .rise (ws_rise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk  (clk),
    .rst  (rst),
    .d    (i2s_din),
    .q    (din_s_p0),
    .rise (din_rise_unused)
  );

  ch_e                     ws_q;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_W-1:0]       shreg;
  logic                    synced;
  logic                    have_l;
  logic signed [DATA_W-1:0] hold_l;

  logic                     ws_edge;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     slot_ok;
  logic signed [DATA_W-1:0] word;

  // The rise that sees WS change carries the LSB of the outgoing channel
  // (the I2S one-bit delay). Until DATA_W bits have been taken, that LSB
  // completes the word. Once DATA_W bits are in, any extra slot bits are
  // ignored.
  always_comb begin
    ws_edge = (ch_e'(ws_s_p0) != ws_q);
    cnt_inc = cnt_sat_inc(cnt);
    slot_ok = (cnt_inc == SLOT_CNT);
    word    = (cnt < DATA_CNT) ? {shreg[DATA_W-2:0], din_s_p0} : shreg;
  end

  // ---- stage p1: slot deserialiser, left hold, completed frame ----
  logic                     vld_p1;
  logic signed [DATA_W-1:0] frm_l_p1;
  logic signed [DATA_W-1:0] frm_r_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_q     <= I2S_WS_LEFT;
      cnt      <= '0;
      shreg    <= '0;
      synced   <= 1'b0;
      have_l   <= 1'b0;
      hold_l   <= '0;
      slot_err <= 1'b0;
      vld_p1   <= 1'b0;
      frm_l_p1 <= '0;
      frm_r_p1 <= '0;
    end else begin
      slot_err <= 1'b0;
      vld_p1   <= 1'b0;
      if (bck_rise_p0) begin
        ws_q <= ch_e'(ws_s_p0);
        if (ws_edge) begin
          cnt   <= '0;
          shreg <= '0;
          if (!synced) begin
            // The first WS edge after reset only sets alignment.
            // The partial slot before it is thrown away.
            synced <= 1'b1;
            have_l <= 1'b0;
          end else if (!slot_ok) begin
            slot_err <= 1'b1;
            have_l   <= 1'b0;
          end else if (ws_q == I2S_WS_LEFT) begin
            hold_l <= word;
            have_l <= 1'b1;
          end else begin
            // A right word is only paired with a good left word held
            // just before it. Otherwise it is dropped without a flag.
            have_l <= 1'b0;
            if (have_l) begin
              vld_p1   <= 1'b1;
              frm_l_p1 <= hold_l;
              frm_r_p1 <= word;
            end
          end
        end else begin
          cnt <= cnt_inc;
          if (cnt < DATA_CNT) begin
            shreg <= {shreg[DATA_W-2:0], din_s_p0};
          end
        end
      end
    end
  end

  // ---- stage p2: output register with valid/ready handshake ----
  // A new frame may replace the held one in the same clk that the held
  // frame is accepted. If it cannot, the new frame is lost and overrun
  // pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (vld_p1) begin
        if (!out_valid || out_ready) begin
          out_l     <= frm_l_p1;
          out_r     <= frm_r_p1;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
//   Directed bench for i2s_rx. A bit-level I2S source drives BCK at 1/18 of
//   clk (27 MHz vs 1.5 MHz). A small monitor logs accepted frames and error
//   pulses. All expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  localparam int H = 9;  // clk periods per BCK phase

  logic               clk = 1'b0;
  logic               rst;
  logic               i2s_bck;
  logic               i2s_ws;
  logic               i2s_din;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               slot_err;

  int vectors     = 0;
  int miscompares = 0;
  int ovr_cnt     = 0;
  int err_cnt     = 0;
  int ovr_base;
  int err_base;
  logic [31:0] rxq[$];

  i2s_rx dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_bck   (i2s_bck),
    .i2s_ws    (i2s_ws),
    .i2s_din   (i2s_din),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .slot_err  (slot_err)
  );

  always #18 clk = ~clk;

  // Sampled 1 ns after the falling edge. The handshake seen here is the one
  // that the next rising edge will act on.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) rxq.push_back({out_l, out_r});
    if (overrun)  ovr_cnt++;
    if (slot_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rxq.size()) return rxq[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // One BCK period: WS/DIN change with the falling edge, then H clk later
  // BCK rises. The task is entered and left on a falling clk edge.
  task automatic bck_bit(input logic ws, input logic d);
    i2s_bck = 1'b0;
    i2s_ws  = ws;
    i2s_din = d;
    repeat (H) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // One channel slot of nbits. The LSB goes out with WS already switched to
  // the other channel.
  task automatic send_word(input logic ch, input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 1; i--) bck_bit(ch, w[i]);
    bck_bit(~ch, w[0]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, l, 16);
    send_word(1'b1, r, 16);
  endtask

  // Sends the right word. The call returns just after the 4th clk edge
  // (edges 0..3) that has sampled BCK=1 for the right LSB. The caller must
  // then finish the high phase with repeat (H-4) @(negedge clk).
  task automatic right_to_edge3(input logic [15:0] r);
    for (int i = 15; i >= 1; i--) bck_bit(1'b1, r[i]);
    i2s_bck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_din = r[0];
    repeat (H) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [15:0] tab [4];

  initial begin
    rst       = 1'b1;
    i2s_bck   = 1'b0;
    i2s_ws    = 1'b0;
    i2s_din   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_l",     32'(out_l),     32'h0);
    chk("rst_out_r",     32'(out_r),     32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_overrun",   32'(overrun),   32'h0);
    chk("rst_slot_err",  32'(slot_err),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: the first frame only aligns. Frames 2..4 then come out as
    // 7FFF/8001. Frame 4 is also used to check the output latency.
    ovr_base = ovr_cnt;
    err_base = err_cnt;
    send_frame(16'h7FFF, 16'h8001);
    send_frame(16'h7FFF, 16'h8001);
    send_frame(16'h7FFF, 16'h8001);
    send_word(1'b0, 16'h7FFF, 16);
    right_to_edge3(16'h8001);
    chk("lat_valid_edge3", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("lat_valid_edge4", 32'(out_valid), 32'h1);
    chk("lat_data_edge4",  {out_l, out_r}, 32'h7FFF_8001);
    repeat (H - 5) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t1_count",   32'(rxq.size()), 32'd3);
    chk("t1_frame0",  q_at(0), 32'h7FFF_8001);
    chk("t1_frame1",  q_at(1), 32'h7FFF_8001);
    chk("t1_frame2",  q_at(2), 32'h7FFF_8001);
    chk("t1_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    chk("t1_slot_err", 32'(err_cnt - err_base), 32'd0);

    // Test 2: extreme values pass through without change (L == R).
    rxq.delete();
    tab[0] = 16'h8000; tab[1] = 16'hFFFF; tab[2] = 16'h5A82; tab[3] = 16'h0001;
    for (int i = 0; i < 4; i++) send_frame(tab[i], tab[i]);
    repeat (2) @(negedge clk);
    chk("t2_count", 32'(rxq.size()), 32'd4);
    chk("t2_f0", q_at(0), 32'h8000_8000);
    chk("t2_f1", q_at(1), 32'hFFFF_FFFF);
    chk("t2_f2", q_at(2), 32'h5A82_5A82);
    chk("t2_f3", q_at(3), 32'h0001_0001);

    // Test 3: backpressure for 3 frames. Frame 1 is held and overrun pulses
    // twice. Frame 4 is the next frame accepted.
    rxq.delete();
    ovr_base  = ovr_cnt;
    out_ready = 1'b0;
    send_frame(16'h0101, 16'hF0F0);
    send_frame(16'h0202, 16'hE0E0);
    send_frame(16'h0303, 16'hD0D0);
    chk("t3_valid_held", 32'(out_valid), 32'h1);
    chk("t3_data_held",  {out_l, out_r}, 32'h0101_F0F0);
    chk("t3_overruns",   32'(ovr_cnt - ovr_base), 32'd2);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_valid_drained", 32'(out_valid), 32'h0);
    send_frame(16'h0404, 16'hC0C0);
    repeat (2) @(negedge clk);
    chk("t3_count",  32'(rxq.size()), 32'd2);
    chk("t3_first",  q_at(0), 32'h0101_F0F0);
    chk("t3_fourth", q_at(1), 32'h0404_C0C0);

    // Test 4: a 15-bit right slot gives one slot_err and no frame. The next
    // good frame comes out normally.
    rxq.delete();
    err_base = err_cnt;
    send_word(1'b0, 16'hAAAA, 16);
    send_word(1'b1, 16'h5555, 15);
    send_frame(16'h1234, 16'h5678);
    repeat (2) @(negedge clk);
    chk("t4_slot_err", 32'(err_cnt - err_base), 32'd1);
    chk("t4_count",    32'(rxq.size()), 32'd1);
    chk("t4_frame",    q_at(0), 32'h1234_5678);

    // Test 6: ready is raised in the same clk that a new frame completes
    // while the output is full. The new frame loads with no overrun.
    rxq.delete();
    ovr_base  = ovr_cnt;
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    send_word(1'b0, 16'h3333, 16);
    right_to_edge3(16'h4444);
    chk("t6_held_before", {out_l, out_r}, 32'h1111_2222);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_valid_after", 32'(out_valid), 32'h1);
    chk("t6_data_after",  {out_l, out_r}, 32'h3333_4444);
    repeat (H - 5) @(negedge clk);
    chk("t6_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    chk("t6_count1",  32'(rxq.size()), 32'd1);
    chk("t6_g1",      q_at(0), 32'h1111_2222);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_g2", q_at(1), 32'h3333_4444);

    // Test 5: reset in the middle of the left slot. Outputs clear at once.
    // The interrupted frame only re-aligns, and the next frame is correct.
    out_ready = 1'b0;
    send_frame(16'hBEEF, 16'hCAFE);
    chk("t5_valid_pre", 32'(out_valid), 32'h1);
    for (int i = 15; i >= 8; i--) bck_bit(1'b0, 1'(16'h1357 >> i));
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_l",     32'(out_l),     32'h0);
    chk("t5_rst_r",     32'(out_r),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    err_base  = err_cnt;
    out_ready = 1'b1;
    for (int i = 7; i >= 1; i--) bck_bit(1'b0, 1'(16'h1357 >> i));
    bck_bit(1'b1, 1'b1);
    send_word(1'b1, 16'h2468, 16);
    send_frame(16'h0F0F, 16'h7070);
    repeat (2) @(negedge clk);
    chk("t5_count",    32'(rxq.size()), 32'd1);
    chk("t5_frame",    q_at(0), 32'h0F0F_7070);
    chk("t5_slot_err", 32'(err_cnt - err_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
